// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
//   UART receive deserializer: input synchroniser, bit FSM and shift register in
//   one block. Each bit is decided by a 2-of-3 majority vote around the bit centre.
//   False starts are rejected. Parity, framing and break conditions are reported
//   alongside every completed word.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-low reset
//   acq_sig     oversample tick from the baud generator (1-clk pulse, may be held high)
//   rx          asynchronous serial line, idle high
//   big_end     1: first data bit lands in data[DATA_W-1]; 0: first bit lands in data[0]
//   parity_en   1: a parity bit follows the data bits
//   parity_odd  1: odd parity; 0: even parity
//   stop2       1: two stop bits; 0: one stop bit
//   data        last received word, held until the next valid
//   valid       1-clk pulse per completed frame (error frames included)
//   parity_err  parity check result for the current data
//   frame_err   a stop bit was sampled 0
//   break_det   every data, parity and stop bit of the frame was 0
//   busy        receiver is inside a frame
//   rx_synch    start edge seen while idle (combinational, 1 clk)
//
// Sampling alignment: the tick on which the first 0 enters the synchroniser is
// treated as cnt=0 of the start bit, so cnt=c always refers to sample c of the
// current bit.
module uart_rx_deserializer #(
  parameter int DATA_W    = 8,
  parameter int OVS       = 16,
  parameter int ACQ_POINT = 7,
  parameter int SYNC_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acq_sig,
  input  logic              rx,
  input  logic              big_end,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop2,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              break_det,
  output logic              busy,
  output logic              rx_synch
);

  localparam int CNT_W = $clog2(OVS);
  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_START  = 5'b00010,
    S_DATA   = 5'b00100,
    S_PARITY = 5'b01000,
    S_STOP   = 5'b10000
  } state_t;

  state_t            state;
  logic [SYNC_W-1:0] sync;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [1:0]        samp;
  logic [DATA_W-1:0] sh;
  logic              perr_q;
  logic              ferr_q;
  logic              any_one;
  logic              big_end_q;
  logic              parity_en_q;
  logic              parity_odd_q;
  logic              stop2_q;

  logic              line;
  logic              maj;
  logic              decide;
  logic              wrap;
  logic              last_data;
  logic              last_stop;
  logic [IDX_W-1:0]  dst_idx;

  // The vote sample is the same stage whose 1->0 transition marks the start edge.
  assign line      = sync[SYNC_W-2];
  // Third vote sample is the live one on the decision tick.
  assign maj       = (samp[0] & samp[1]) | (samp[0] & line) | (samp[1] & line);
  assign decide    = (cnt == CNT_W'(ACQ_POINT + 1));
  assign wrap      = (cnt == CNT_W'(OVS - 1));
  assign last_data = (bit_idx == IDX_W'(DATA_W - 1));
  assign last_stop = (bit_idx == IDX_W'(stop2_q));
  assign dst_idx   = big_end_q ? (IDX_W'(DATA_W - 1) - bit_idx) : bit_idx;

  // Edge check uses the stages as they stood before this tick's shift, so the
  // tick that detects the edge is sample 1 of the start bit.
  assign rx_synch  = (state == S_IDLE) && acq_sig && sync[SYNC_W-1] && !sync[SYNC_W-2];
  assign busy      = (state != S_IDLE);

  // NOTE: sequential state uses <= so every register sees its peers' pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge; the synchroniser loads 1s so the
    // idle-high line cannot look like a start edge when reset releases.
    if (!rst) begin
      sync         <= '1;
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      samp         <= '0;
      sh           <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      any_one      <= 1'b0;
      big_end_q    <= 1'b0;
      parity_en_q  <= 1'b0;
      parity_odd_q <= 1'b0;
      stop2_q      <= 1'b0;
      data         <= '0;
      valid        <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (acq_sig) sync <= {sync[SYNC_W-2:0], rx};

      if (rx_synch) begin
        // Modes are frozen for the whole frame from here on.
        state        <= S_START;
        cnt          <= CNT_W'(1);
        bit_idx      <= '0;
        sh           <= '0;
        perr_q       <= 1'b0;
        ferr_q       <= 1'b0;
        any_one      <= 1'b0;
        big_end_q    <= big_end;
        parity_en_q  <= parity_en;
        parity_odd_q <= parity_odd;
        stop2_q      <= stop2;
      end else if (acq_sig && state != S_IDLE) begin
        cnt <= wrap ? '0 : cnt + CNT_W'(1);
        if (cnt == CNT_W'(ACQ_POINT - 1)) samp[0] <= line;
        if (cnt == CNT_W'(ACQ_POINT))     samp[1] <= line;

        case (state)
          S_START: begin
            // A start bit that votes high was a glitch: drop it silently.
            if (decide && maj) state <= S_IDLE;
            else if (wrap)     state <= S_DATA;
          end
          S_DATA: begin
            if (decide) begin
              sh[dst_idx] <= maj;
              any_one     <= any_one | maj;
            end
            if (wrap) begin
              if (last_data) begin
                bit_idx <= '0;
                state   <= parity_en_q ? S_PARITY : S_STOP;
              end else begin
                bit_idx <= bit_idx + IDX_W'(1);
              end
            end
          end
          S_PARITY: begin
            if (decide) begin
              perr_q  <= ^sh ^ maj ^ parity_odd_q;
              any_one <= any_one | maj;
            end
            if (wrap) state <= S_STOP;
          end
          S_STOP: begin
            if (decide) begin
              if (last_stop) begin
                // Finish at the decision tick rather than the wrap so a start
                // edge right after the stop bit is not missed.
                state      <= S_IDLE;
                valid      <= 1'b1;
                data       <= sh;
                parity_err <= perr_q;
                frame_err  <= ferr_q | ~maj;
                break_det  <= ~(any_one | maj);
              end else begin
                ferr_q  <= ferr_q | ~maj;
                any_one <= any_one | maj;
              end
            end
            if (wrap) bit_idx <= bit_idx + IDX_W'(1);
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Testbench for uart_rx_deserializer. Three instances (DATA_W = 8, 5, 9) share
// the tick and mode inputs; only the selected instance sees serial traffic.
// Frames are built bit by bit from payload and modes; expected results come from
// a frame-level model (payload, parity by popcount, stop/break by inspection).
module tb_uart_rx_deserializer;

  localparam int OVS = 16;
  localparam int AP  = 7;

  typedef struct packed {
    logic [1:0] inst;
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  logic acq;
  logic line;
  logic big_end, parity_en, parity_odd, stop2;
  int   cur_sel;
  int   acq_gap;
  logic rx8, rx5, rx9;

  logic [7:0] d8;
  logic [4:0] d5;
  logic [8:0] d9;
  logic v8, pe8, fe8, bk8, busy8, sy8;
  logic v5, pe5, fe5, bk5, busy5, sy5;
  logic v9, pe9, fe9, bk9, busy9, sy9;

  int n_checks;
  int n_fail;
  int synch_cnt = 0;
  obs_t mon_q[$];
  logic [8:0] last_data[3];

  assign rx8 = (cur_sel == 0) ? line : 1'b1;
  assign rx5 = (cur_sel == 1) ? line : 1'b1;
  assign rx9 = (cur_sel == 2) ? line : 1'b1;

  always #5 clk = ~clk;

  uart_rx_deserializer #(.DATA_W(8), .OVS(OVS), .ACQ_POINT(AP), .SYNC_W(3)) u_w8 (
    .clk(clk), .rst(rst), .acq_sig(acq), .rx(rx8), .big_end(big_end),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .data(d8), .valid(v8), .parity_err(pe8), .frame_err(fe8), .break_det(bk8),
    .busy(busy8), .rx_synch(sy8));

  uart_rx_deserializer #(.DATA_W(5), .OVS(OVS), .ACQ_POINT(AP), .SYNC_W(3)) u_w5 (
    .clk(clk), .rst(rst), .acq_sig(acq), .rx(rx5), .big_end(big_end),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .data(d5), .valid(v5), .parity_err(pe5), .frame_err(fe5), .break_det(bk5),
    .busy(busy5), .rx_synch(sy5));

  uart_rx_deserializer #(.DATA_W(9), .OVS(OVS), .ACQ_POINT(AP), .SYNC_W(3)) u_w9 (
    .clk(clk), .rst(rst), .acq_sig(acq), .rx(rx9), .big_end(big_end),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .data(d9), .valid(v9), .parity_err(pe9), .frame_err(fe9), .break_det(bk9),
    .busy(busy9), .rx_synch(sy9));

  // Collect every completed frame from all instances.
  always @(negedge clk) begin
    if (v8) mon_q.push_back('{inst: 2'd0, d: 9'(d8), pe: pe8, fe: fe8, brk: bk8});
    if (v5) mon_q.push_back('{inst: 2'd1, d: 9'(d5), pe: pe5, fe: fe5, brk: bk5});
    if (v9) mon_q.push_back('{inst: 2'd2, d: d9, pe: pe9, fe: fe9, brk: bk9});
    if (sy8 || sy5 || sy9) synch_cnt++;
  end

  function automatic int wid(input int sel);
    case (sel)
      1:       return 5;
      2:       return 9;
      default: return 8;
    endcase
  endfunction

  function automatic logic [8:0] wmask(input int sel);
    return (9'd1 << wid(sel)) - 9'd1;
  endfunction

  // Frame-level reference model.
  function automatic obs_t model_frame(input int sel, input logic [8:0] payload, input bit pen,
                                       input bit odd, input logic pbit, input bit two_stop,
                                       input logic [1:0] stops);
    obs_t o;
    logic [8:0] d;
    d     = payload & wmask(sel);
    o.inst = 2'(sel);
    o.d   = d;
    o.pe  = pen && ((($countones(d) + int'(pbit)) % 2) != int'(odd));
    o.fe  = !stops[0] || (two_stop && !stops[1]);
    o.brk = (d == 9'd0) && !(pen && pbit) && !stops[0] && !(two_stop && stops[1]);
    return o;
  endfunction

  task automatic do_tick(input logic lvl);
    line = lvl;
    acq  = 1'b1;
    @(posedge clk); #1;
    acq  = 1'b0;
    repeat (acq_gap) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) do_tick(1'b1);
  endtask

  // Drive one frame; spike_bit >= 0 inverts that frame bit for the single tick at
  // the bit centre. scramble randomises the mode pins after the start bit.
  task automatic send_frame(input int sel, input logic [8:0] payload, input bit be,
                            input bit pen, input bit odd, input logic pbit, input bit two_stop,
                            input logic [1:0] stops, input int spike_bit, input bit scramble);
    logic bits[$];
    int   w;
    w          = wid(sel);
    cur_sel    = sel;
    big_end    = be;
    parity_en  = pen;
    parity_odd = odd;
    stop2      = two_stop;
    bits.push_back(1'b0);
    for (int k = 0; k < w; k++) bits.push_back(be ? payload[w-1-k] : payload[k]);
    if (pen) bits.push_back(pbit);
    bits.push_back(stops[0]);
    if (two_stop) bits.push_back(stops[1]);
    foreach (bits[b]) begin
      for (int c = 0; c < OVS; c++) begin
        if (scramble && b == 1 && c == 0) begin
          big_end    = 1'($urandom);
          parity_en  = 1'($urandom);
          parity_odd = 1'($urandom);
          stop2      = 1'($urandom);
        end
        do_tick((b == spike_bit && c == AP) ? ~bits[b] : bits[b]);
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({d8, v8, pe8, fe8, bk8, busy8, sy8} !== '0) begin
      n_fail++; $display("FAIL reset_w8: got %h, expected 0", {d8, v8, pe8, fe8, bk8, busy8, sy8});
    end
    n_checks++;
    if ({d5, v5, pe5, fe5, bk5, busy5, sy5} !== '0) begin
      n_fail++; $display("FAIL reset_w5: got %h, expected 0", {d5, v5, pe5, fe5, bk5, busy5, sy5});
    end
    n_checks++;
    if ({d9, v9, pe9, fe9, bk9, busy9, sy9} !== '0) begin
      n_fail++; $display("FAIL reset_w9: got %h, expected 0", {d9, v9, pe9, fe9, bk9, busy9, sy9});
    end
  endtask

  task automatic test_basic();
    obs_t exp;
    int   base, s0;
    base = mon_q.size();
    s0   = synch_cnt;
    send_frame(0, 9'h0A5, 0, 0, 0, 1'b0, 0, 2'b11, -1, 0);
    idle(4);
    exp = model_frame(0, 9'h0A5, 0, 0, 1'b0, 0, 2'b11);
    last_data[0] = exp.d;
    n_checks++;
    if (mon_q.size() != base + 1) begin
      n_fail++; $display("FAIL basic_count: got %0d frames, expected 1", mon_q.size() - base);
    end else begin
      n_checks++;
      if (mon_q[base] !== exp) begin
        n_fail++; $display("FAIL basic_frame: got %h, expected %h", mon_q[base], exp);
      end
    end
    n_checks++;
    if (synch_cnt - s0 != 1) begin
      n_fail++; $display("FAIL basic_synch: got %0d start edges, expected 1", synch_cnt - s0);
    end
    n_checks++;
    if (busy8 !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_after: got %b, expected 0", busy8);
    end
  endtask

  task automatic test_parity();
    obs_t exp;
    int   base;
    for (int odd = 0; odd < 2; odd++) begin
      base = mon_q.size();
      send_frame(0, 9'h03C, 1, 1, 1'(odd), 1'b1, 0, 2'b11, -1, 0);
      idle(4);
      exp = model_frame(0, 9'h03C, 1, 1'(odd), 1'b1, 0, 2'b11);
      last_data[0] = exp.d;
      n_checks++;
      if (mon_q.size() != base + 1) begin
        n_fail++; $display("FAIL parity_count odd=%0d: got %0d frames, expected 1", odd, mon_q.size() - base);
      end else begin
        n_checks++;
        if (mon_q[base] !== exp) begin
          n_fail++; $display("FAIL parity_frame odd=%0d: got %h, expected %h", odd, mon_q[base], exp);
        end
      end
    end
  endtask

  task automatic test_false_start();
    int base;
    base    = mon_q.size();
    cur_sel = 0;
    repeat (4) do_tick(1'b0);
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++; $display("FAIL false_start_busy_rise: got %b, expected 1", busy8);
    end
    repeat (12) do_tick(1'b1);
    n_checks++;
    if (busy8 !== 1'b0) begin
      n_fail++; $display("FAIL false_start_busy_fall: got %b, expected 0", busy8);
    end
    idle(8);
    n_checks++;
    if (mon_q.size() != base) begin
      n_fail++; $display("FAIL false_start_valid: got %0d frames, expected 0", mon_q.size() - base);
    end
    n_checks++;
    if (9'(d8) !== last_data[0]) begin
      n_fail++; $display("FAIL false_start_data: got %h, expected %h", d8, last_data[0]);
    end
  endtask

  task automatic test_majority();
    obs_t       exp;
    int         base;
    logic [8:0] pl;
    for (int be = 0; be < 2; be++) begin
      pl   = 9'($urandom_range(0, 255)) | 9'h010;
      base = mon_q.size();
      // Data bit 4 is 1; spike its centre sample low.
      send_frame(0, pl, 1'(be), 0, 0, 1'b0, 0, 2'b11, (be != 0) ? 1 + 3 : 1 + 4, 0);
      idle(4);
      exp = model_frame(0, pl, 0, 0, 1'b0, 0, 2'b11);
      last_data[0] = exp.d;
      n_checks++;
      if (mon_q.size() != base + 1) begin
        n_fail++; $display("FAIL majority_count be=%0d: got %0d frames, expected 1", be, mon_q.size() - base);
      end else begin
        n_checks++;
        if (mon_q[base] !== exp) begin
          n_fail++; $display("FAIL majority_frame be=%0d: got %h, expected %h", be, mon_q[base], exp);
        end
      end
    end
  endtask

  task automatic test_stop_errors();
    obs_t       exp;
    int         base;
    logic [8:0] pl;
    logic [1:0] stops;
    bit         two;
    for (int k = 0; k < 3; k++) begin
      // 0: 8N2 good, 1: 8N2 second stop low, 2: line low for a whole frame.
      pl    = (k == 2) ? 9'h000 : 9'($urandom_range(0, 255));
      stops = (k == 0) ? 2'b11 : (k == 1) ? 2'b01 : 2'b00;
      two   = (k != 2);
      base  = mon_q.size();
      send_frame(0, pl, 0, 0, 0, 1'b0, two, stops, -1, 0);
      idle(4);
      exp = model_frame(0, pl, 0, 0, 1'b0, two, stops);
      last_data[0] = exp.d;
      n_checks++;
      if (mon_q.size() != base + 1) begin
        n_fail++; $display("FAIL stop_count case=%0d: got %0d frames, expected 1", k, mon_q.size() - base);
      end else begin
        n_checks++;
        if (mon_q[base] !== exp) begin
          n_fail++; $display("FAIL stop_frame case=%0d: got %h, expected %h", k, mon_q[base], exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t       exp0, exp1;
    int         base;
    logic [8:0] p0, p1;
    p0   = 9'($urandom_range(0, 255));
    p1   = 9'($urandom_range(0, 255));
    base = mon_q.size();
    send_frame(0, p0, 0, 1, 0, ^p0[7:0], 0, 2'b11, -1, 0);
    send_frame(0, p1, 1, 0, 0, 1'b0, 0, 2'b11, -1, 0);
    idle(4);
    exp0 = model_frame(0, p0, 1, 0, ^p0[7:0], 0, 2'b11);
    exp1 = model_frame(0, p1, 0, 0, 1'b0, 0, 2'b11);
    last_data[0] = exp1.d;
    n_checks++;
    if (mon_q.size() != base + 2) begin
      n_fail++; $display("FAIL b2b_count: got %0d frames, expected 2", mon_q.size() - base);
    end else begin
      n_checks++;
      if (mon_q[base] !== exp0) begin
        n_fail++; $display("FAIL b2b_frame0: got %h, expected %h", mon_q[base], exp0);
      end
      n_checks++;
      if (mon_q[base+1] !== exp1) begin
        n_fail++; $display("FAIL b2b_frame1: got %h, expected %h", mon_q[base+1], exp1);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    obs_t exp;
    int   base;
    base    = mon_q.size();
    cur_sel = 0;
    repeat (OVS) do_tick(1'b0);
    repeat (OVS) do_tick(1'b1);
    repeat (OVS) do_tick(1'b0);
    repeat (OVS / 2) do_tick(1'b1);
    line = 1'b1;
    rst  = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({d8, v8, pe8, fe8, bk8, busy8, sy8} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h, expected 0", {d8, v8, pe8, fe8, bk8, busy8, sy8});
    end
    rst = 1'b1;
    last_data[0] = 9'h000;
    idle(2 * OVS);
    n_checks++;
    if (mon_q.size() != base) begin
      n_fail++; $display("FAIL reset_mid_abort: got %0d frames, expected 0", mon_q.size() - base);
    end
    send_frame(0, 9'h05A, 0, 0, 0, 1'b0, 0, 2'b11, -1, 0);
    idle(4);
    exp = model_frame(0, 9'h05A, 0, 0, 1'b0, 0, 2'b11);
    last_data[0] = exp.d;
    n_checks++;
    if (mon_q.size() != base + 1) begin
      n_fail++; $display("FAIL reset_mid_count: got %0d frames, expected 1", mon_q.size() - base);
    end else begin
      n_checks++;
      if (mon_q[base] !== exp) begin
        n_fail++; $display("FAIL reset_mid_frame: got %h, expected %h", mon_q[base], exp);
      end
    end
  endtask

  task automatic test_widths();
    obs_t       exp;
    int         base, spk;
    logic [8:0] pl;
    logic       pb;
    for (int s = 1; s <= 2; s++) begin
      for (int k = 0; k < 4; k++) begin
        pl   = (k == 2) ? 9'h000 : 9'($urandom);
        base = mon_q.size();
        case (k)
          0: begin
            send_frame(s, pl, 0, 0, 0, 1'b0, 0, 2'b11, -1, 0);
            exp = model_frame(s, pl, 0, 0, 1'b0, 0, 2'b11);
          end
          1: begin
            pb = 1'b1 ^ (^(pl & wmask(s)));
            send_frame(s, pl, 1, 1, 0, pb, 0, 2'b11, -1, 0);
            exp = model_frame(s, pl, 1, 0, pb, 0, 2'b11);
          end
          2: begin
            send_frame(s, pl, 0, 0, 0, 1'b0, 0, 2'b00, -1, 0);
            exp = model_frame(s, pl, 0, 0, 1'b0, 0, 2'b00);
          end
          default: begin
            spk = $urandom_range(1, wid(s));
            send_frame(s, pl, 1, 0, 0, 1'b0, 1, 2'b11, spk, 0);
            exp = model_frame(s, pl, 0, 0, 1'b0, 1, 2'b11);
          end
        endcase
        idle(4);
        n_checks++;
        if (mon_q.size() != base + 1) begin
          n_fail++; $display("FAIL width_count w=%0d case=%0d: got %0d frames, expected 1", wid(s), k, mon_q.size() - base);
        end else begin
          n_checks++;
          if (mon_q[base] !== exp) begin
            n_fail++; $display("FAIL width_frame w=%0d case=%0d: got %h, expected %h", wid(s), k, mon_q[base], exp);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    obs_t       exp;
    int         base, s, nbits, spk;
    logic [8:0] pl;
    bit         be, pen, odd, two, scr;
    logic       pb;
    logic [1:0] stops;
    for (int i = 0; i < 24; i++) begin
      s       = $urandom_range(0, 2);
      acq_gap = $urandom_range(0, 2);
      pl      = 9'($urandom);
      be      = 1'($urandom);
      pen     = 1'($urandom);
      odd     = 1'($urandom);
      two     = 1'($urandom);
      scr     = 1'($urandom);
      pb      = 1'($urandom);
      stops   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      nbits   = 2 + wid(s) + int'(pen) + int'(two);
      spk     = ($urandom_range(0, 1) == 1) ? $urandom_range(1, nbits - 1) : -1;
      base    = mon_q.size();
      send_frame(s, pl, be, pen, odd, pb, two, stops, spk, scr);
      idle(4);
      exp = model_frame(s, pl, pen, odd, pb, two, stops);
      n_checks++;
      if (mon_q.size() != base + 1) begin
        n_fail++; $display("FAIL random_count iter=%0d: got %0d frames, expected 1", i, mon_q.size() - base);
      end else begin
        n_checks++;
        if (mon_q[base] !== exp) begin
          n_fail++; $display("FAIL random_frame iter=%0d: got %h, expected %h", i, mon_q[base], exp);
        end
      end
    end
    acq_gap = 0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    cur_sel    = 0;
    acq_gap    = 0;
    line       = 1'b1;
    acq        = 1'b0;
    big_end    = 1'b0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;
    rst        = 1'b0;
    foreach (last_data[i]) last_data[i] = 9'h000;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    idle(8);
    test_basic();
    test_parity();
    test_false_start();
    test_majority();
    test_stop_errors();
    test_back_to_back();
    test_reset_mid_frame();
    test_widths();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
